// File: rtl/lemmings_pkg.sv
// lemmings_pkg: lane state encoding and output decode shared by the lemming lanes.
package lemmings_pkg;
  typedef enum logic [2:0] {WL, WR, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT} lane_state_t;
  // Returns {walk_left, walk_right, aaah, digging}; SPLAT decodes to all zeros.
  function automatic logic [3:0] decode(input lane_state_t s);
    return (s == WL) ? 4'b1000 :
           (s == WR) ? 4'b0100 :
           (s == FALL_L || s == FALL_R) ? 4'b0010 :
           (s == DIG_L || s == DIG_R) ? 4'b0001 : 4'b0000;
  endfunction
endpackage

// File: rtl/lemming_lane.sv
// lemming_lane: one lemming Moore FSM with a saturating fall counter for splat detection.
module lemming_lane
  import lemmings_pkg::*;
#(
  parameter int SPLAT_CYCLES = 20,
  parameter bit START_RIGHT = 1'b0
) (
  input  logic clk,
  input  logic areset,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic alive
);
  localparam int CW = $clog2(SPLAT_CYCLES + 2);
  localparam logic [CW-1:0] LIMIT = CW'(SPLAT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(SPLAT_CYCLES + 1);
  localparam lane_state_t RST_STATE = START_RIGHT ? WR : WL;
  lane_state_t state, next;
  logic [CW-1:0] cnt, cnt_next;
  logic in_fall, to_fall;
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      state <= RST_STATE;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= cnt_next;
    end
  always_comb begin
    case (state)
      WL:      next = !ground ? FALL_L : dig ? DIG_L : bump_left ? WR : WL;
      WR:      next = !ground ? FALL_R : dig ? DIG_R : bump_right ? WL : WR;
      DIG_L:   next = ground ? DIG_L : FALL_L;
      DIG_R:   next = ground ? DIG_R : FALL_R;
      FALL_L:  next = !ground ? FALL_L : (cnt > LIMIT) ? SPLAT : WL;
      FALL_R:  next = !ground ? FALL_R : (cnt > LIMIT) ? SPLAT : WR;
      default: next = state;
    endcase
    in_fall = (state == FALL_L) || (state == FALL_R);
    to_fall = (next == FALL_L) || (next == FALL_R);
    // cnt tracks aaah cycles including the current one, saturating so it never wraps
    cnt_next = !to_fall ? '0 : !in_fall ? CW'(1) : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  end
  always_comb begin
    {walk_left, walk_right, aaah, digging} = decode(state);
    alive = state != SPLAT;
  end
endmodule

// File: rtl/lemmings_array.sv
// lemmings_array: N independent lemming lanes plus a count of lanes that have not splatted.
module lemmings_array
  import lemmings_pkg::*;
#(
  parameter int N = 4,
  parameter int SPLAT_CYCLES = 20,
  parameter bit START_RIGHT = 1'b0
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [N-1:0]           bump_left,
  input  logic [N-1:0]           bump_right,
  input  logic [N-1:0]           ground,
  input  logic [N-1:0]           dig,
  output logic [N-1:0]           walk_left,
  output logic [N-1:0]           walk_right,
  output logic [N-1:0]           aaah,
  output logic [N-1:0]           digging,
  output logic [$clog2(N+1)-1:0] alive_count
);
  localparam int AW = $clog2(N + 1);
  logic [N-1:0] alive;
  for (genvar g = 0; g < N; g++) begin : g_lane
    lemming_lane #(.SPLAT_CYCLES(SPLAT_CYCLES), .START_RIGHT(START_RIGHT)) u_lane (
      .clk(clk),
      .areset(areset),
      .bump_left(bump_left[g]),
      .bump_right(bump_right[g]),
      .ground(ground[g]),
      .dig(dig[g]),
      .walk_left(walk_left[g]),
      .walk_right(walk_right[g]),
      .aaah(aaah[g]),
      .digging(digging[g]),
      .alive(alive[g])
    );
  end
  always_comb begin
    alive_count = '0;
    for (int i = 0; i < N; i++) alive_count = alive_count + AW'(alive[i]);
  end
endmodule

// File: tb/tb_lemmings_array.sv
// tb_lemmings_array: directed checks of reset, bumps, dig, fall threshold and splat recovery.
module tb_lemmings_array;
  logic clk = 1'b0;
  logic areset;
  logic [3:0] bump_left, bump_right, ground, dig;
  logic [3:0] walk_left, walk_right, aaah, digging;
  logic [2:0] alive_count;
  logic [3:0] walk_left_r, walk_right_r, aaah_r, digging_r;
  logic [2:0] alive_count_r;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lemmings_array #(.N(4), .SPLAT_CYCLES(20), .START_RIGHT(1'b0)) dut (
    .clk(clk), .areset(areset), .bump_left(bump_left), .bump_right(bump_right),
    .ground(ground), .dig(dig), .walk_left(walk_left), .walk_right(walk_right),
    .aaah(aaah), .digging(digging), .alive_count(alive_count)
  );

  lemmings_array #(.N(4), .SPLAT_CYCLES(20), .START_RIGHT(1'b1)) dut_r (
    .clk(clk), .areset(areset), .bump_left(bump_left), .bump_right(bump_right),
    .ground(ground), .dig(dig), .walk_left(walk_left_r), .walk_right(walk_right_r),
    .aaah(aaah_r), .digging(digging_r), .alive_count(alive_count_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] wl, input logic [3:0] wr,
                         input logic [3:0] a, input logic [3:0] d, input logic [2:0] al);
    chk({tag, ".walk_left"}, 32'(walk_left), 32'(wl));
    chk({tag, ".walk_right"}, 32'(walk_right), 32'(wr));
    chk({tag, ".aaah"}, 32'(aaah), 32'(a));
    chk({tag, ".digging"}, 32'(digging), 32'(d));
    chk({tag, ".alive_count"}, 32'(alive_count), 32'(al));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bump_left = '0;
    bump_right = '0;
    dig = '0;
    ground = 4'hF;
  endtask

  initial begin
    idle();
    areset = 1'b1;
    #3;
    chk_all("reset", 4'hF, 4'h0, 4'h0, 4'h0, 3'd4);
    chk("reset_r.walk_right", 32'(walk_right_r), 32'hF);
    chk("reset_r.walk_left", 32'(walk_left_r), 32'h0);
    chk("reset_r.alive", 32'(alive_count_r), 32'd4);
    areset = 1'b0;
    tick();
    chk_all("idle", 4'hF, 4'h0, 4'h0, 4'h0, 3'd4);
    // lane 0 bump_left turns it right; bump_right alone is ignored while walking left
    bump_left = 4'b0001;
    bump_right = 4'b0010;
    tick();
    chk_all("bump_left", 4'b1110, 4'b0001, 4'h0, 4'h0, 3'd4);
    chk("bump_left_r.walk_right", 32'(walk_right_r), 32'hD);
    bump_left = 4'b0001;
    bump_right = 4'b0001;
    tick();
    chk_all("bump_both", 4'hF, 4'h0, 4'h0, 4'h0, 3'd4);
    chk("bump_both_r.walk_left", 32'(walk_left_r), 32'b0011);
    idle();
    bump_left = 4'b0010;
    tick();
    chk_all("lane1_right", 4'b1101, 4'b0010, 4'h0, 4'h0, 3'd4);
    // 20-cycle fall survives
    idle();
    ground = 4'b1101;
    for (int i = 1; i <= 20; i++) begin
      bump_left = (i == 5) ? 4'b0010 : 4'b0000;
      tick();
      chk($sformatf("fall20_c%0d.aaah", i), 32'(aaah), 32'b0010);
    end
    idle();
    tick();
    chk_all("land20", 4'b1101, 4'b0010, 4'h0, 4'h0, 3'd4);
    // 21-cycle fall splats
    ground = 4'b1101;
    for (int i = 1; i <= 21; i++) tick();
    chk_all("fall21", 4'b1101, 4'h0, 4'b0010, 4'h0, 3'd4);
    idle();
    tick();
    chk_all("splat21", 4'b1101, 4'h0, 4'h0, 4'h0, 3'd3);
    bump_left = 4'b0010;
    bump_right = 4'b0010;
    dig = 4'b0010;
    tick();
    ground = 4'b1101;
    tick();
    chk_all("splat_hold", 4'b1101, 4'h0, 4'h0, 4'h0, 3'd3);
    // dig beats bump on lane 2
    idle();
    dig = 4'b0100;
    bump_left = 4'b0100;
    tick();
    chk_all("dig", 4'b1001, 4'h0, 4'h0, 4'b0100, 3'd3);
    idle();
    ground = 4'b1011;
    bump_left = 4'b0100;
    tick();
    chk_all("dig_fall", 4'b1001, 4'h0, 4'b0100, 4'h0, 3'd3);
    tick();
    tick();
    idle();
    tick();
    chk_all("dig_land", 4'b1101, 4'h0, 4'h0, 4'h0, 3'd3);
    // fall beats dig on lane 3
    ground = 4'b0111;
    dig = 4'b1000;
    tick();
    chk_all("fall_vs_dig", 4'b0101, 4'h0, 4'b1000, 4'h0, 3'd3);
    dig = 4'b0000;
    tick();
    idle();
    tick();
    chk_all("fall_land", 4'b1101, 4'h0, 4'h0, 4'h0, 3'd3);
    // async reset clears the splatted lane without a clock edge
    #2;
    areset = 1'b1;
    #1;
    chk_all("reset_mid", 4'hF, 4'h0, 4'h0, 4'h0, 3'd4);
    #1;
    areset = 1'b0;
    tick();
    ground = 4'b1010;
    for (int i = 1; i <= 21; i++) tick();
    idle();
    tick();
    chk_all("splat02", 4'b1010, 4'h0, 4'h0, 4'h0, 3'd2);
    chk("splat02_r.alive", 32'(alive_count_r), 32'd2);
    #2;
    areset = 1'b1;
    #1;
    chk_all("recover", 4'hF, 4'h0, 4'h0, 4'h0, 3'd4);
    chk("recover_r.walk_right", 32'(walk_right_r), 32'hF);
    chk("recover_r.alive", 32'(alive_count_r), 32'd4);
    areset = 1'b0;
    tick();
    chk_all("post_recover", 4'hF, 4'h0, 4'h0, 4'h0, 3'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lemmings_array.md
Name: lemmings_array

Overview:
- N independent lemming-controller lanes, one Moore FSM per lane, sharing one clock and reset.
- Generalises the two-state walk-left/walk-right controller. Each lane adds falling, digging and splat (fall-too-long) behaviour.
- Fall threshold, lane count and initial direction are parametrised.
- An aggregate count of surviving lanes is provided for the game-status logic.

Parameters:
- N, 4, number of independent lemming lanes (1..32).
- SPLAT_CYCLES, 20, maximum number of aaah cycles a lemming survives; more than this causes a splat on landing.
- START_RIGHT, 0, reset direction: 0 = all lanes walk left, 1 = all lanes walk right.

Ports:
- clk  input  1  rising-edge clock.
- areset  input  1  asynchronous, active-high reset.
- bump_left  input  N  per-lane obstacle on left.
- bump_right  input  N  per-lane obstacle on right.
- ground  input  N  per-lane ground present (1 = ground).
- dig  input  N  per-lane dig command.
- walk_left  output  N  lane walking left.
- walk_right  output  N  lane walking right.
- aaah  output  N  lane falling.
- digging  output  N  lane digging.
- alive_count  output  $clog2(N+1)  number of lanes not in SPLAT.

Behaviour:
- Clock and reset: one clock `clk`. Reset `areset` is asynchronous and active-high; it forces every lane to the reset state immediately, independent of clk.
- Reset state:
  - Each lane enters WL (START_RIGHT=0) or WR (START_RIGHT=1).
  - Fall counter is 0.
  - Outputs: walk_left = all-ones (or walk_right = all-ones), every other per-lane output 0, alive_count = N.
- Lane states: WL, WR, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT. State is registered.
- Outputs are pure Moore decode of state, so outputs change one edge after the causing input. Exactly one output is 1 per lane, except in SPLAT, where all four are 0.
- Transitions, evaluated per lane each rising edge, priority top-down:
  - WL:
    - ground=0 -> FALL_L.
    - else dig=1 -> DIG_L.
    - else bump_left=1 -> WR.
    - else stay. bump_right is ignored.
  - WR:
    - ground=0 -> FALL_R.
    - else dig=1 -> DIG_R.
    - else bump_right=1 -> WL.
    - else stay.
  - Simultaneous bump_left and bump_right: the lane reverses direction (the rule of its current state applies).
  - DIG_L / DIG_R:
    - ground=0 -> FALL_L / FALL_R.
    - else stay. Bumps and dig are ignored.
  - FALL_L / FALL_R:
    - ground=1 and fall_cnt > SPLAT_CYCLES -> SPLAT.
    - ground=1 otherwise -> WL / WR, returning to the pre-fall direction.
    - ground=0 -> stay. Bumps and dig are ignored throughout the fall, and on the landing edge.
  - SPLAT: terminal; the lane leaves only on areset.
- Fall counter, per lane, width $clog2(SPLAT_CYCLES+2):
  - Meaning: the number of cycles aaah has been high, including the current cycle.
  - Set to 1 on the edge entering FALL_x.
  - Increments on each edge that stays in FALL_x.
  - Saturates at SPLAT_CYCLES+1 and never wraps.
  - Cleared to 0 in all other states.
- Threshold boundary: aaah high for exactly SPLAT_CYCLES cycles survives; SPLAT_CYCLES+1 cycles splats.
- alive_count: combinational popcount of lanes not in SPLAT.
- Lanes are fully independent. No lane's inputs affect another lane's state.
- areset mid-fall or while in SPLAT: the lane returns to the reset direction immediately and its counter clears.

Decomposition:
- Shared package lemmings_pkg holds:
  - the lane state enum (WL, WR, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT);
  - a function decoding state to the {walk_left, walk_right, aaah, digging} 4-bit vector.
- Sub-module lemming_lane:
  - contains one lane FSM plus its fall counter, parametrised by SPLAT_CYCLES and START_RIGHT;
  - is instantiated N times in a generate loop.
- The top level holds only the generate loop and the alive_count popcount.

Test Plan:
- Reset: assert areset mid-cycle with N=4 -> walk_left=4'hF, others 0, alive_count=4 without waiting for a clock edge. Repeat with START_RIGHT=1 -> walk_right=4'hF.
- Bump priority (lane 0):
  - bump_left=1 for one cycle -> walk_right[0]=1 after the edge.
  - Then bump_left=1 and bump_right=1 together -> walk_left[0]=1.
  - Lanes 1..3 stay unchanged throughout.
- Fall threshold, lane 1 walking right, SPLAT_CYCLES=20:
  - ground[1]=0 for 20 cycles, then 1 -> aaah[1] high exactly 20 cycles, then walk_right[1]=1.
  - Repeat with 21 cycles -> all lane-1 outputs 0 permanently, alive_count=3.
  - bump_left pulsed during the fall -> no effect.
- Dig, lane 2:
  - dig[2]=1 with bump_left[2]=1 -> digging[2]=1 (dig beats bump).
  - Then ground[2]=0 -> aaah[2].
  - Then ground=1 after 3 cycles -> walk_left[2]=1, not digging.
- Fall beats dig: ground[3]=0 and dig[3]=1 on the same edge -> aaah[3]=1. Landing after 2 cycles -> walk resumes, digging[3]=0.
- Splat recovery: splat lanes 0 and 2 -> alive_count=2. Then assert areset -> alive_count=4 and all lanes in the reset direction.
